// File: rtl/phase_readout_pkg.sv
// Shared constants and types for the Ising-array phase readout block.
package phase_readout_pkg;

  localparam logic [31:0] READOUT_STATUS_ADDR = 32'h0000_0000;
  localparam logic [31:0] READOUT_SPIN_BASE   = 32'h0000_0004;
  localparam logic [31:0] READOUT_CNT_BASE    = 32'h0000_0400;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_LATCH  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rd_beat_t;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for an asynchronous oscillator phase.
module sync_ff #(
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_DEPTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) stage <= '0;
    else     stage <= {stage[SYNC_DEPTH-2:0], d};
  end

  assign q = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/phase_readout.sv
// Samples oscillator phases over a fixed window, reduces them to spin bits
// relative to oscillator 0, and serves results over an AXI-lite read channel.
module phase_readout
  import phase_readout_pkg::*;
#(
  parameter int unsigned NUM_SPINS  = 32,
  parameter int unsigned WINDOW     = 1024,
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 axi_rst,
  input  logic [NUM_SPINS-1:0] phase_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 arvalid,
  input  logic [31:0]          araddr,
  output logic                 arready,
  output logic                 rvalid,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  input  logic                 rready
);

  localparam int unsigned CW         = $clog2(WINDOW + 1);
  localparam int unsigned SW         = CW + 2;
  localparam int unsigned NSW        = (NUM_SPINS + 31) / 32;
  localparam int unsigned SPIN_PAD_W = NSW * 32;
  localparam int unsigned IW         = (NUM_SPINS > 1) ? $clog2(NUM_SPINS) : 1;
  localparam int unsigned KW         = (NSW > 1) ? $clog2(NSW) : 1;

  localparam logic [29:0] STATUS_WORD = 30'(READOUT_STATUS_ADDR >> 2);
  localparam logic [29:0] SPIN_WORD   = 30'(READOUT_SPIN_BASE >> 2);
  localparam logic [29:0] CNT_WORD    = 30'(READOUT_CNT_BASE >> 2);

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [NUM_SPINS-1:0][CW-1:0] agree_q, agree_d, agree_inc;
  logic [NUM_SPINS-1:0][CW-1:0] shadow_cnt_q, shadow_cnt_d;
  logic [NUM_SPINS-1:0]         shadow_spin_q, shadow_spin_d, spin_calc;
  logic                         busy_d, done_d;
  logic [NUM_SPINS-1:0]         ph_s;
  logic [NUM_SPINS-1:0]         agree_hit;

  // Per-spin synchronizer, saturating agreement increment and majority decision.
  for (genvar g = 0; g < NUM_SPINS; g++) begin : g_spin
    sync_ff #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
      .clk (clk),
      .rst (axi_rst),
      .d   (phase_in[g]),
      .q   (ph_s[g])
    );
    assign agree_hit[g] = ~(ph_s[g] ^ ph_s[0]);
    assign agree_inc[g] = (agree_hit[g] && (agree_q[g] != CW'(WINDOW)))
                          ? agree_q[g] + CW'(1) : agree_q[g];
    if (g == 0) begin : g_ref
      assign spin_calc[g] = 1'b1;
    end else begin : g_cmp
      assign spin_calc[g] = ({1'b0, agree_q[g], 1'b0} > SW'(WINDOW));
    end
  end

  // Measurement FSM: next state and registered-output next values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    agree_d       = agree_q;
    busy_d        = busy;
    done_d        = done;
    shadow_cnt_d  = shadow_cnt_q;
    shadow_spin_d = shadow_spin_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
          agree_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SAMPLE: begin
        agree_d = agree_inc;
        cnt_d   = (cnt_q == CW'(WINDOW)) ? cnt_q : cnt_q + CW'(1);
        if (cnt_q == CW'(WINDOW - 1)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        shadow_cnt_d  = agree_q;
        shadow_spin_d = spin_calc;
        busy_d        = 1'b0;
        done_d        = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      agree_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      shadow_cnt_q  <= '0;
      shadow_spin_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      agree_q       <= agree_d;
      busy          <= busy_d;
      done          <= done_d;
      shadow_cnt_q  <= shadow_cnt_d;
      shadow_spin_q <= shadow_spin_d;
    end
  end

  // Read address decode; byte-lane bits of the address are don't-care.
  logic [NSW-1:0][31:0] spin_words;
  logic [29:0]          spin_off, cnt_off;
  logic                 unused_addr_lsb;
  rd_beat_t             rd_c;

  assign spin_words      = SPIN_PAD_W'(shadow_spin_q);
  assign spin_off        = araddr[31:2] - SPIN_WORD;
  assign cnt_off         = araddr[31:2] - CNT_WORD;
  assign unused_addr_lsb = ^araddr[1:0];

  always_comb begin
    rd_c.resp = RRESP_SLVERR;
    rd_c.data = '0;
    if (araddr[31:2] == STATUS_WORD) begin
      rd_c.resp = RRESP_OKAY;
      rd_c.data = {30'b0, done, busy};
    end else if (spin_off < 30'(NSW)) begin
      rd_c.resp = RRESP_OKAY;
      rd_c.data = spin_words[spin_off[KW-1:0]];
    end else if (cnt_off < 30'(NUM_SPINS)) begin
      rd_c.resp = RRESP_OKAY;
      rd_c.data = 32'(shadow_cnt_q[cnt_off[IW-1:0]]);
    end
  end

  // Single-outstanding read channel; response held until rready.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      rvalid  <= 1'b0;
      arready <= 1'b1;
      rdata   <= '0;
      rresp   <= RRESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid  <= 1'b1;
      arready <= 1'b0;
      rdata   <= rd_c.data;
      rresp   <= rd_c.resp;
    end else if (rvalid && rready) begin
      rvalid  <= 1'b0;
      arready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_readout.sv
// Scoreboard bench for phase_readout: measurement scenarios and AXI-lite reads.
module tb_phase_readout;

  localparam int unsigned NS  = 40;
  localparam int unsigned WIN = 4;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic          clk = 1'b0;
  logic          axi_rst = 1'b1;
  logic [NS-1:0] phase_in = '0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          arvalid = 1'b0;
  logic [31:0]   araddr = '0;
  logic          arready, rvalid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rready = 1'b1;

  int   n_vec = 0;
  int   n_err = 0;
  int   tick  = 0;
  int   mode  = 0;
  exp_t sb_q[$];

  phase_readout #(.NUM_SPINS(NS), .WINDOW(WIN), .SYNC_DEPTH(2)) dut (
    .clk      (clk),
    .axi_rst  (axi_rst),
    .phase_in (phase_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .arvalid  (arvalid),
    .araddr   (araddr),
    .arready  (arready),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rresp    (rresp),
    .rready   (rready)
  );

  always #5 clk = ~clk;

  // mode 0: all in phase; 1: spin 1 anti-phase at clk/8; 2: spin 1 toggles every cycle
  function automatic logic [NS-1:0] pattern(input int m, input int t);
    logic [NS-1:0] p;
    logic          b;
    b = t[2];
    p = '1;
    case (m)
      1: begin p = b ? '1 : '0; p[1] = ~b; end
      2: p[1] = t[0];
      default: p = '1;
    endcase
    return p;
  endfunction

  function automatic int exp_cnt(input int m, input int i);
    if (i == 1 && m == 1) return 0;
    if (i == 1 && m == 2) return WIN / 2;
    return WIN;
  endfunction

  function automatic logic [31:0] exp_spin_word(input int m, input int k);
    logic [31:0] w;
    int          i;
    w = '0;
    for (int b = 0; b < 32; b++) begin
      i = 32 * k + b;
      if (i < NS) w[b] = (i == 0) ? 1'b1 : (2 * exp_cnt(m, i) > WIN);
    end
    return w;
  endfunction

  task automatic step();
    @(negedge clk);
    tick++;
    phase_in = pattern(mode, tick);
  endtask

  task automatic collect(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin step(); n++; end
    e = sb_q.pop_front();
    n_vec++;
    if (rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL %s: rvalid=%b never rose, required 1", name, rvalid);
    end else if (rdata !== e.data || rresp !== e.resp) begin
      n_err++;
      $display("FAIL %s: rdata=%h rresp=%b, required rdata=%h rresp=%b",
               name, rdata, rresp, e.data, e.resp);
    end
    step();
  endtask

  task automatic rd(input string name, input logic [31:0] addr,
                    input logic [31:0] ed, input logic [1:0] er);
    int n;
    sb_q.push_back('{data: ed, resp: er});
    step();
    arvalid = 1'b1;
    araddr  = addr;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin step(); n++; end
    if (arready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL %s: arready=%b never rose, required 1", name, arready);
    end
    step();
    arvalid = 1'b0;
    collect(name);
  endtask

  task automatic measure(input int m, input bit restart);
    int k;
    mode = m;
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL start_busy: busy=%b done=%b, required 1 0", busy, done);
    end
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      if (restart && k == 1) start = 1'b1;
      step();
      start = 1'b0;
      k++;
    end
    n_vec++;
    if (k != WIN + 1) begin
      n_err++;
      $display("FAIL done_latency: %0d cycles, required %0d", k, WIN + 1);
    end
    step();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL after_done: busy=%b done=%b, required 0 1", busy, done);
    end
  endtask

  task automatic test_reset();
    axi_rst = 1'b1;
    repeat (2) step();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || arready !== 1'b1 || rvalid !== 1'b0 ||
        rdata !== 32'h0 || rresp !== 2'b00) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b arready=%b rvalid=%b rdata=%h rresp=%b, required 0 0 1 0 0 00",
               busy, done, arready, rvalid, rdata, rresp);
    end
    axi_rst = 1'b0;
    rd("reset_status", 32'h000, 32'h0, 2'b00);
  endtask

  task automatic test_in_phase();
    measure(0, 1'b0);
    rd("status_done", 32'h000, 32'h2, 2'b00);
    rd("inphase_spin0", 32'h004, exp_spin_word(0, 0), 2'b00);
    rd("inphase_spin1", 32'h008, exp_spin_word(0, 1), 2'b00);
    rd("inphase_cnt1_lsb", 32'h407, 32'(exp_cnt(0, 1)), 2'b00);
    rd("inphase_cnt0", 32'h400, 32'(exp_cnt(0, 0)), 2'b00);
    rd("inphase_cnt_last", 32'h49C, 32'(exp_cnt(0, NS - 1)), 2'b00);
  endtask

  task automatic test_start_with_read();
    int k;
    step();
    sb_q.push_back('{data: 32'h2, resp: 2'b00});
    n_vec++;
    if (arready !== 1'b1) begin
      n_err++;
      $display("FAIL swr_arready: arready=%b, required 1", arready);
    end
    start   = 1'b1;
    arvalid = 1'b1;
    araddr  = 32'h000;
    step();
    start   = 1'b0;
    arvalid = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL swr_busy: busy=%b, required 1", busy);
    end
    collect("swr_status");
    k = 0;
    while (done !== 1'b1 && k < 40) begin step(); k++; end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL swr_done: done=%b, required 1", done);
    end
  endtask

  task automatic test_anti_phase();
    measure(1, 1'b0);
    rd("anti_spin0", 32'h004, exp_spin_word(1, 0), 2'b00);
    rd("anti_spin1", 32'h008, exp_spin_word(1, 1), 2'b00);
    rd("anti_cnt1", 32'h404, 32'(exp_cnt(1, 1)), 2'b00);
    rd("anti_cnt2", 32'h408, 32'(exp_cnt(1, 2)), 2'b00);
  endtask

  task automatic test_tie();
    measure(2, 1'b0);
    rd("tie_spin0", 32'h004, exp_spin_word(2, 0), 2'b00);
    rd("tie_cnt1", 32'h404, 32'(exp_cnt(2, 1)), 2'b00);
  endtask

  task automatic test_backpressure();
    int   n;
    exp_t e;
    rready = 1'b0;
    sb_q.push_back('{data: 32'(exp_cnt(2, 2)), resp: 2'b00});
    step();
    arvalid = 1'b1;
    araddr  = 32'h408;
    step();
    araddr  = 32'h000;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin step(); n++; end
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== e.data || rresp !== e.resp) begin
        n_err++;
        $display("FAIL bp_stall%0d: rvalid=%b arready=%b rdata=%h rresp=%b, required 1 0 %h %b",
                 c, rvalid, arready, rdata, rresp, e.data, e.resp);
      end
      step();
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL bp_release%0d: rvalid=%b, required 0", c, rvalid);
      end
      step();
    end
  endtask

  task automatic test_abort_bad_addr();
    measure(0, 1'b1);
    mode  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    axi_rst = 1'b1;
    step();
    axi_rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort: busy=%b done=%b, required 0 0", busy, done);
    end
    rd("abort_status", 32'h000, 32'h0, 2'b00);
    rd("abort_spin0", 32'h004, 32'h0, 2'b00);
    rd("abort_cnt1", 32'h404, 32'h0, 2'b00);
    rd("bad_300", 32'h300, 32'h0, 2'b10);
    rd("bad_spin_word2", 32'h00C, 32'h0, 2'b10);
    rd("bad_cnt_past_end", 32'h4A0, 32'h0, 2'b10);
  endtask

  initial begin
    test_reset();
    test_in_phase();
    test_start_with_read();
    test_anti_phase();
    test_tie();
    test_backpressure();
    test_abort_bad_addr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
